spiflash_bram_v2: RTL and testbench

- Parametrised SPI-flash emulator for the caravel simulation harness and FPGA bring-up; successor to the fixed read-only spiflash model.
- Serves management-core flash fetches from a 32-bit BRAM port (romcode_* bus) on its own ap_clk, oversampling the SPI pins.
- Adds FAST_READ with configurable dummy cycles, a JEDEC ID response, address wrap at ROM size, word prefetch, and status outputs.

---
 rtl/spiflash_bram_v2_if.sv | 22 ++
 rtl/spiflash_bram_v2.sv | 203 ++++++++++++++++++++
 tb/tb_spiflash_bram_v2.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spiflash_bram_v2_if.sv
// BRAM port bundle between the SPI-flash emulator (master) and its ROM (slave).
interface spiflash_bram_v2_if;
    logic [31:0] romcode_Addr_A;
    logic        romcode_EN_A;
    logic [3:0]  romcode_WEN_A;
    logic [31:0] romcode_Din_A;
    logic [31:0] romcode_Dout_A;
    logic        romcode_Clk_A;
    logic        romcode_Rst_A;

    modport master (
        output romcode_Addr_A, romcode_EN_A, romcode_WEN_A, romcode_Din_A,
               romcode_Clk_A, romcode_Rst_A,
        input  romcode_Dout_A
    );

    modport slave (
        input  romcode_Addr_A, romcode_EN_A, romcode_WEN_A, romcode_Din_A,
               romcode_Clk_A, romcode_Rst_A,
        output romcode_Dout_A
    );
endinterface

// File: rtl/spiflash_bram_v2.sv
// SPI-flash emulator: oversamples mode-0 SPI on ap_clk and serves READ, FAST_READ
// and JEDEC ID from a 32-bit BRAM port with word prefetch and address wrap.
module spiflash_bram_v2 #(
    parameter int          ADDR_BITS    = 24,
    parameter int          ROM_BYTES    = 65536,
    parameter int          DUMMY_CYCLES = 8,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               csb,
    input  logic               spiclk,
    input  logic               io0,
    output logic               io1,
    output logic               io1_oe,
    spiflash_bram_v2_if.master romcode,
    output logic [31:0]        bytes_served,
    output logic               cmd_err
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

    localparam logic [31:0] ROM_MASK   = 32'(ROM_BYTES - 1);
    localparam logic [7:0]  ADDR_LAST  = 8'(ADDR_BITS - 1);
    localparam logic [7:0]  DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    logic [SYNC_STAGES-1:0] csb_sr, clk_sr, io0_sr;
    logic                   clk_prev;
    logic                   csb_s, clk_s, io0_s, rise, fall;

    state_t      state_q, state_d;
    logic [7:0]  cnt;
    logic [30:0] sh;
    logic        fast_q, jedec_q;
    logic [1:0]  jed_idx;
    logic [31:0] a_q, addr_q, hold_q;
    logic        en_q, en_d1;

    logic [7:0]  op_byte, cur_byte;
    logic        op_unsup, out_bit;
    logic [31:0] addr_lat, a_next, word_sel;

    assign csb_s = csb_sr[SYNC_STAGES-1];
    assign clk_s = clk_sr[SYNC_STAGES-1];
    assign io0_s = io0_sr[SYNC_STAGES-1];
    assign rise  = clk_s & ~clk_prev;
    assign fall  = ~clk_s & clk_prev;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            csb_sr   <= '1;
            clk_sr   <= '0;
            io0_sr   <= '0;
            clk_prev <= 1'b0;
        end else begin
            csb_sr   <= {csb_sr[SYNC_STAGES-2:0], csb};
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], spiclk};
            io0_sr   <= {io0_sr[SYNC_STAGES-2:0], io0};
            clk_prev <= clk_s;
        end
    end

    assign op_byte  = {sh[6:0], io0_s};
    assign op_unsup = !(op_byte inside {8'h03, 8'h0B, 8'h9F, 8'hAB, 8'hFF});
    assign addr_lat = {sh[30:0], io0_s} & ROM_MASK;
    assign a_next   = (a_q + 32'd1) & ROM_MASK;

    // Bypass the holding register on the cycle the BRAM word returns, so a
    // fetch issued on a rising edge is usable by the very next falling edge.
    assign word_sel = en_d1 ? romcode.romcode_Dout_A : hold_q;

    always_comb begin
        cur_byte = word_sel[{a_q[1:0], 3'b000} +: 8];
        if (jedec_q) begin
            case (jed_idx)
                2'd0:    cur_byte = JEDEC_ID[23:16];
                2'd1:    cur_byte = JEDEC_ID[15:8];
                2'd2:    cur_byte = JEDEC_ID[7:0];
                default: cur_byte = 8'hFF;
            endcase
        end
        out_bit = cur_byte[3'd7 - cnt[2:0]];
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = CMD;
            CMD: begin
                if (rise && cnt == 8'd7) begin
                    case (op_byte)
                        8'h03, 8'h0B: state_d = ADDR;
                        8'h9F:        state_d = DATA;
                        default:      state_d = IGNORE;
                    endcase
                end
            end
            ADDR: begin
                if (rise && cnt == ADDR_LAST)
                    state_d = (fast_q && DUMMY_CYCLES > 0) ? DUMMY : DATA;
            end
            DUMMY: if (rise && cnt == DUMMY_LAST) state_d = DATA;
            default: ;
        endcase
        if (csb_s) state_d = IDLE;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt          <= '0;
            sh           <= '0;
            fast_q       <= 1'b0;
            jedec_q      <= 1'b0;
            jed_idx      <= '0;
            a_q          <= '0;
            addr_q       <= '0;
            hold_q       <= '0;
            en_q         <= 1'b0;
            en_d1        <= 1'b0;
            io1          <= 1'b0;
            io1_oe       <= 1'b0;
            bytes_served <= '0;
            cmd_err      <= 1'b0;
        end else begin
            en_q  <= 1'b0;
            en_d1 <= en_q;
            if (en_d1) hold_q <= romcode.romcode_Dout_A;
            if (csb_s) begin
                cnt    <= '0;
                io1    <= 1'b0;
                io1_oe <= 1'b0;
            end else begin
                case (state_q)
                    CMD: if (rise) begin
                        if (cnt == 8'd7) begin
                            cnt     <= '0;
                            sh      <= '0;
                            fast_q  <= (op_byte == 8'h0B);
                            jedec_q <= (op_byte == 8'h9F);
                            jed_idx <= '0;
                            if (op_unsup) cmd_err <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
                            sh  <= {sh[29:0], io0_s};
                        end
                    end
                    ADDR: if (rise) begin
                        if (cnt == ADDR_LAST) begin
                            cnt    <= '0;
                            a_q    <= addr_lat;
                            addr_q <= {addr_lat[31:2], 2'b00};
                            en_q   <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
                            sh  <= {sh[29:0], io0_s};
                        end
                    end
                    DUMMY: if (rise) cnt <= (cnt == DUMMY_LAST) ? '0 : cnt + 8'd1;
                    DATA: begin
                        if (fall) begin
                            io1    <= out_bit;
                            io1_oe <= 1'b1;
                        end
                        if (rise) begin
                            if (cnt[2:0] == 3'd7) begin
                                cnt <= '0;
                                if (jedec_q) begin
                                    if (jed_idx != 2'd3) jed_idx <= jed_idx + 2'd1;
                                end else begin
                                    bytes_served <= bytes_served + 32'd1;
                                    a_q          <= a_next;
                                    if (a_next[1:0] == 2'b00) begin
                                        en_q   <= 1'b1;
                                        addr_q <= {a_next[31:2], 2'b00};
                                    end
                                end
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        cnt    <= '0;
                        io1    <= 1'b0;
                        io1_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign romcode.romcode_Addr_A = addr_q;
    assign romcode.romcode_EN_A   = en_q;
    assign romcode.romcode_WEN_A  = '0;
    assign romcode.romcode_Din_A  = '0;
    assign romcode.romcode_Clk_A  = ap_clk;
    assign romcode.romcode_Rst_A  = ap_rst;
endmodule

// File: tb/tb_spiflash_bram_v2.sv
// Bench for spiflash_bram_v2: bit-banged SPI master, BRAM models and a byte-level ROM model.
module tb_spiflash_bram_v2;
    localparam int HALF = 6;

    logic clk = 1'b0, rst = 1'b1;
    logic csb_a = 1'b1, csb_b = 1'b1, spiclk = 1'b0, io0 = 1'b0;
    logic io1_a, oe_a, io1_b, oe_b, err_a, err_b;
    logic [31:0] bs_a, bs_b;

    spiflash_bram_v2_if bus_a ();
    spiflash_bram_v2_if bus_b ();

    always #5 clk = ~clk;

    spiflash_bram_v2 #(.ADDR_BITS(24), .ROM_BYTES(65536), .DUMMY_CYCLES(8),
                       .JEDEC_ID(24'hEF4018), .SYNC_STAGES(2)) u_a (
        .ap_clk(clk), .ap_rst(rst), .csb(csb_a), .spiclk(spiclk), .io0(io0),
        .io1(io1_a), .io1_oe(oe_a), .romcode(bus_a), .bytes_served(bs_a), .cmd_err(err_a));

    spiflash_bram_v2 #(.ADDR_BITS(24), .ROM_BYTES(16), .DUMMY_CYCLES(8),
                       .JEDEC_ID(24'hEF4018), .SYNC_STAGES(2)) u_b (
        .ap_clk(clk), .ap_rst(rst), .csb(csb_b), .spiclk(spiclk), .io0(io0),
        .io1(io1_b), .io1_oe(oe_b), .romcode(bus_b), .bytes_served(bs_b), .cmd_err(err_b));

    logic [31:0] mem [16384];
    always @(posedge clk) begin
        if (bus_a.romcode_EN_A) bus_a.romcode_Dout_A <= mem[bus_a.romcode_Addr_A[15:2]];
        if (bus_b.romcode_EN_A) bus_b.romcode_Dout_A <= mem[{12'd0, bus_b.romcode_Addr_A[3:2]}];
    end

    int unsigned en_a = 0, en_b = 0, oe_cnt_a = 0;
    logic [31:0] addr_q_b [$];
    always @(posedge clk) begin
        if (bus_a.romcode_EN_A) en_a++;
        if (bus_b.romcode_EN_A) begin
            en_b++;
            addr_q_b.push_back(bus_b.romcode_Addr_A);
        end
        if (oe_a) oe_cnt_a++;
    end

    int checks = 0, errors = 0;
    bit sel_b = 1'b0;
    logic [7:0] rx_buf [16];
    int unsigned exp_bs_a = 0, exp_bs_b = 0;
    logic exp_err = 1'b0;

    function automatic logic [7:0] rom_byte(input int unsigned b, input int unsigned rom);
        int unsigned x;
        logic [31:0] w;
        x = b % rom;
        w = mem[x / 4];
        return w[8*(x % 4) +: 8];
    endfunction

    function automatic int unsigned exp_fetches(input int unsigned s, input int unsigned n,
                                                input int unsigned rom);
        int unsigned c = 1;
        for (int unsigned k = 1; k <= n; k++)
            if (((s + k) % rom) % 4 == 0) c++;
        return c;
    endfunction

    task automatic spi_bit(input logic mosi, output logic miso);
        io0 = mosi;
        repeat (HALF) @(negedge clk);
        miso = sel_b ? io1_b : io1_a;
        spiclk = 1'b1;
        repeat (HALF) @(negedge clk);
        spiclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        if (sel_b) csb_b = 1'b0; else csb_a = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        csb_a = 1'b1;
        csb_b = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic b;
        for (int i = 23; i >= 0; i--) spi_bit(a[i], b);
    endtask

    task automatic read_txn(input logic [7:0] op, input logic [23:0] start, input int unsigned n);
        logic [7:0] r;
        logic b;
        cs_low();
        spi_byte(op, r);
        if (op != 8'h9F) send_addr(start);
        if (op == 8'h0B) for (int i = 0; i < 8; i++) spi_bit(1'($urandom), b);
        for (int unsigned k = 0; k < n; k++) begin
            spi_byte(8'($urandom), r);
            rx_buf[k] = r;
        end
        cs_high();
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (io1_a !== 1'b0 || oe_a !== 1'b0) begin errors++; $display("FAIL reset_io1: io1=%b oe=%b want 0 0", io1_a, oe_a); end
        checks++; if (bus_a.romcode_EN_A !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", bus_a.romcode_EN_A); end
        checks++; if (bus_a.romcode_Addr_A !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus_a.romcode_Addr_A); end
        checks++; if (bs_a !== 32'd0 || bs_b !== 32'd0) begin errors++; $display("FAIL reset_bytes: got %0d/%0d want 0", bs_a, bs_b); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_a); end
        checks++; if (bus_a.romcode_WEN_A !== 4'd0 || bus_a.romcode_Din_A !== 32'd0) begin errors++; $display("FAIL reset_wr: wen=%h din=%h want 0", bus_a.romcode_WEN_A, bus_a.romcode_Din_A); end
        checks++; if (bus_a.romcode_Clk_A !== clk || bus_a.romcode_Rst_A !== rst) begin errors++; $display("FAIL clk_rst_pass: clk=%b rst=%b want %b %b", bus_a.romcode_Clk_A, bus_a.romcode_Rst_A, clk, rst); end
    endtask

    task automatic test_read_basic();
        logic [7:0] r;
        int unsigned en0 = en_a;
        cs_low();
        spi_byte(8'h03, r);
        send_addr(24'h000000);
        for (int unsigned k = 0; k < 8; k++) begin
            if (k == 7) begin
                checks++; if (en_a - en0 !== 2) begin errors++; $display("FAIL basic_en_before_last: got %0d want 2", en_a - en0); end
            end
            spi_byte(8'($urandom), r);
            checks++; if (r !== rom_byte(k, 65536)) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", k, r, rom_byte(k, 65536)); end
        end
        cs_high();
        exp_bs_a += 8;
        checks++; if (bs_a !== exp_bs_a) begin errors++; $display("FAIL basic_bytes_served: got %0d want %0d", bs_a, exp_bs_a); end
        checks++; if (en_a - en0 !== exp_fetches(0, 8, 65536)) begin errors++; $display("FAIL basic_en_total: got %0d want %0d", en_a - en0, exp_fetches(0, 8, 65536)); end
    endtask

    task automatic test_fast_read();
        logic [7:0] r;
        logic b;
        int unsigned oe0;
        cs_low();
        spi_byte(8'h0B, r);
        send_addr(24'h000005);
        oe0 = oe_cnt_a;
        for (int i = 0; i < 8; i++) spi_bit(1'($urandom), b);
        checks++; if (oe_cnt_a !== oe0 || oe_a !== 1'b0) begin errors++; $display("FAIL fast_dummy_oe: oe cycles %0d oe=%b want 0 0", oe_cnt_a - oe0, oe_a); end
        repeat (HALF) @(negedge clk);
        checks++; if (oe_a !== 1'b1) begin errors++; $display("FAIL fast_oe_rise: got %b want 1", oe_a); end
        for (int unsigned k = 0; k < 4; k++) begin
            spi_byte(8'($urandom), r);
            checks++; if (r !== rom_byte(5 + k, 65536)) begin errors++; $display("FAIL fast_byte%0d: got %h want %h", k, r, rom_byte(5 + k, 65536)); end
        end
        cs_high();
        exp_bs_a += 4;
        checks++; if (bs_a !== exp_bs_a) begin errors++; $display("FAIL fast_bytes_served: got %0d want %0d", bs_a, exp_bs_a); end
    endtask

    task automatic test_random_reads();
        for (int it = 0; it < 4; it++) begin
            logic [7:0] op = ($urandom_range(0, 1) == 1) ? 8'h0B : 8'h03;
            int unsigned s = (it == 0) ? 65534 : $urandom_range(0, 65535);
            int unsigned n = $urandom_range(1, 6);
            int unsigned en0 = en_a;
            read_txn(op, 24'(s), n);
            for (int unsigned k = 0; k < n; k++) begin
                checks++; if (rx_buf[k] !== rom_byte(s + k, 65536)) begin errors++; $display("FAIL rand%0d_byte%0d: op %h addr %h got %h want %h", it, k, op, s, rx_buf[k], rom_byte(s + k, 65536)); end
            end
            exp_bs_a += n;
            checks++; if (bs_a !== exp_bs_a) begin errors++; $display("FAIL rand%0d_bytes_served: got %0d want %0d", it, bs_a, exp_bs_a); end
            checks++; if (en_a - en0 !== exp_fetches(s, n, 65536)) begin errors++; $display("FAIL rand%0d_en: got %0d want %0d", it, en_a - en0, exp_fetches(s, n, 65536)); end
        end
    endtask

    task automatic test_wrap();
        int q0 = addr_q_b.size();
        sel_b = 1'b1;
        read_txn(8'h03, 24'h00000E, 4);
        sel_b = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            checks++; if (rx_buf[k] !== rom_byte(14 + k, 16)) begin errors++; $display("FAIL wrap_byte%0d: got %h want %h", k, rx_buf[k], rom_byte(14 + k, 16)); end
        end
        checks++;
        if (addr_q_b.size() - q0 !== 2) begin errors++; $display("FAIL wrap_fetch_count: got %0d want 2", addr_q_b.size() - q0); end
        else if (addr_q_b[q0] !== 32'h0C || addr_q_b[q0+1] !== 32'h00) begin errors++; $display("FAIL wrap_addr_seq: got %h,%h want 0c,00", addr_q_b[q0], addr_q_b[q0+1]); end
        exp_bs_b += 4;
        checks++; if (bs_b !== exp_bs_b) begin errors++; $display("FAIL wrap_bytes_served: got %0d want %0d", bs_b, exp_bs_b); end
    endtask

    task automatic test_jedec();
        logic [7:0] exp_id [5];
        exp_id = '{8'hEF, 8'h40, 8'h18, 8'hFF, 8'hFF};
        read_txn(8'h9F, 24'h0, 5);
        for (int k = 0; k < 5; k++) begin
            checks++; if (rx_buf[k] !== exp_id[k]) begin errors++; $display("FAIL jedec_byte%0d: got %h want %h", k, rx_buf[k], exp_id[k]); end
        end
        checks++; if (bs_a !== exp_bs_a) begin errors++; $display("FAIL jedec_bytes_served: got %0d want %0d", bs_a, exp_bs_a); end
        checks++; if (err_a !== exp_err) begin errors++; $display("FAIL jedec_err: got %b want %b", err_a, exp_err); end
    endtask

    task automatic test_bad_opcode();
        logic [7:0] r;
        logic b;
        int unsigned oe0 = oe_cnt_a;
        int unsigned s = $urandom_range(0, 65535);
        cs_low();
        spi_byte(8'h5A, r);
        for (int i = 0; i < 16; i++) spi_bit(1'($urandom), b);
        cs_high();
        exp_err = 1'b1;
        checks++; if (oe_cnt_a !== oe0) begin errors++; $display("FAIL bad_op_oe: oe high %0d cycles want 0", oe_cnt_a - oe0); end
        checks++; if (err_a !== exp_err) begin errors++; $display("FAIL bad_op_err: got %b want %b", err_a, exp_err); end
        read_txn(8'h03, 24'(s), 3);
        for (int unsigned k = 0; k < 3; k++) begin
            checks++; if (rx_buf[k] !== rom_byte(s + k, 65536)) begin errors++; $display("FAIL post_err_byte%0d: got %h want %h", k, rx_buf[k], rom_byte(s + k, 65536)); end
        end
        exp_bs_a += 3;
        checks++; if (err_a !== exp_err || bs_a !== exp_bs_a) begin errors++; $display("FAIL err_sticky: err=%b bytes=%0d want %b %0d", err_a, bs_a, exp_err, exp_bs_a); end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        logic b;
        cs_low();
        spi_byte(8'h03, r);
        send_addr(24'($urandom_range(0, 65535)));
        spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
        cs_high();
        exp_bs_a += 2;
        checks++; if (bs_a !== exp_bs_a) begin errors++; $display("FAIL abort_bytes_served: got %0d want %0d", bs_a, exp_bs_a); end
        read_txn(8'h03, 24'h000010, 2);
        for (int unsigned k = 0; k < 2; k++) begin
            checks++; if (rx_buf[k] !== rom_byte(16 + k, 65536)) begin errors++; $display("FAIL after_abort_byte%0d: got %h want %h", k, rx_buf[k], rom_byte(16 + k, 65536)); end
        end
        exp_bs_a += 2;
        checks++; if (bs_a !== exp_bs_a) begin errors++; $display("FAIL after_abort_bytes: got %0d want %0d", bs_a, exp_bs_a); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        logic b;
        cs_low();
        spi_byte(8'h03, r);
        send_addr(24'h000100);
        spi_byte(8'h00, r);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        checks++; if (oe_a !== 1'b1 || bus_a.romcode_Addr_A !== 32'h100) begin errors++; $display("FAIL mid_pre: oe=%b addr=%h want 1 100", oe_a, bus_a.romcode_Addr_A); end
        rst = 1'b1;
        @(negedge clk);
        exp_bs_a = 0;
        exp_bs_b = 0;
        exp_err  = 1'b0;
        checks++; if (io1_a !== 1'b0 || oe_a !== 1'b0) begin errors++; $display("FAIL mid_rst_io: io1=%b oe=%b want 0 0", io1_a, oe_a); end
        checks++; if (bus_a.romcode_EN_A !== 1'b0 || bus_a.romcode_Addr_A !== 32'd0) begin errors++; $display("FAIL mid_rst_bus: en=%b addr=%h want 0 0", bus_a.romcode_EN_A, bus_a.romcode_Addr_A); end
        checks++; if (bs_a !== exp_bs_a || bs_b !== exp_bs_b || err_a !== exp_err) begin errors++; $display("FAIL mid_rst_status: bytes=%0d/%0d err=%b want 0 0 0", bs_a, bs_b, err_a); end
        rst = 1'b0;
        cs_high();
    endtask

    initial begin
        for (int unsigned w = 0; w < 16384; w++)
            mem[w] = (w < 8) ? {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)} : $urandom;
        test_reset();
        test_read_basic();
        test_fast_read();
        test_random_reads();
        test_wrap();
        test_jedec();
        test_bad_opcode();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
